// File: rtl/packet_assembler_uart.sv
// Collects UART bytes MSB-first into a PACKET_BYTES packet with a one-deep output register.
// Optional idle timeout for partial packets is enabled by defining PKT_ASM_TIMEOUT_EN.
module packet_assembler_uart #(
  parameter int BYTE_W         = 8,
  parameter int PACKET_BYTES   = 23,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int PACKET_W      = PACKET_BYTES*BYTE_W,
  localparam int CNT_W         = $clog2(PACKET_BYTES+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                byte_ready,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [PACKET_W-1:0] packet,
  output logic [CNT_W-1:0]    byte_count,
  output logic                overflow,
  output logic                timeout
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state;
  logic [PACKET_W-1:0] asm_reg;
  logic [PACKET_W-1:0] asm_next;
  logic                take;
  logic                last_byte;

  assign byte_ready = (state == FILL);
  assign take       = pkt_valid & pkt_ready;
  assign last_byte  = (byte_count == CNT_W'(PACKET_BYTES-1));

  always_comb begin
    asm_next = asm_reg;
    for (int k = 0; k < PACKET_BYTES; k++)
      if (byte_count == CNT_W'(k))
        asm_next[PACKET_W-1-k*BYTE_W -: BYTE_W] = byte_data;
  end

`ifdef PKT_ASM_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES+1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              partial;
  assign partial = (state == FILL) && (byte_count != '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      byte_count <= '0;
      asm_reg    <= '0;
      packet     <= '0;
      pkt_valid  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PKT_ASM_TIMEOUT_EN
      timeout    <= 1'b0;
      idle_cnt   <= '0;
`endif
    end else if (clear) begin
      state      <= FILL;
      byte_count <= '0;
      asm_reg    <= '0;
      pkt_valid  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PKT_ASM_TIMEOUT_EN
      timeout    <= 1'b0;
      idle_cnt   <= '0;
`endif
    end else begin
      // A consumed packet drops valid unless a new one is loaded below.
      if (take)
        pkt_valid <= 1'b0;
`ifdef PKT_ASM_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        FILL: begin
          if (byte_valid) begin
            if (last_byte) begin
              if (!pkt_valid || take) begin
                packet     <= asm_next;
                pkt_valid  <= 1'b1;
                asm_reg    <= '0;
                byte_count <= '0;
              end else begin
                asm_reg    <= asm_next;
                byte_count <= CNT_W'(PACKET_BYTES);
                state      <= HOLD;
              end
            end else begin
              asm_reg    <= asm_next;
              byte_count <= byte_count + 1'b1;
            end
`ifdef PKT_ASM_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (partial) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES-1)) begin
              asm_reg    <= '0;
              byte_count <= '0;
              timeout    <= 1'b1;
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
`endif
          end
        end
        HOLD: begin
          if (byte_valid)
            overflow <= 1'b1;
          if (take) begin
            packet     <= asm_reg;
            pkt_valid  <= 1'b1;
            asm_reg    <= '0;
            byte_count <= '0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_assembler_uart.sv
// Directed bench for packet_assembler_uart with 4-byte packets; inputs change on the falling edge.
module tb_packet_assembler_uart;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [PW-1:0] packet;
  logic [2:0]    byte_count;
  logic          overflow;
  logic          timeout;

  int passed = 0;
  int total  = 0;

  packet_assembler_uart #(.BYTE_W(8), .PACKET_BYTES(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .packet(packet), .byte_count(byte_count),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge after the byte was sampled.
  task automatic drive_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (byte_ready !== 1'b1) $display("FAIL reset_byte_ready got %b exp 1", byte_ready); else passed++;
    total++; if (pkt_valid !== 1'b0) $display("FAIL reset_pkt_valid got %b exp 0", pkt_valid); else passed++;
    total++; if (byte_count !== 3'd0) $display("FAIL reset_byte_count got %0d exp 0", byte_count); else passed++;
    total++; if (packet !== 32'h0) $display("FAIL reset_packet got %h exp 0", packet); else passed++;
    total++; if ({overflow, timeout} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {overflow, timeout}); else passed++;
  endtask

  task automatic test_basic();
    pkt_ready = 1'b1;
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
    total++; if (byte_count !== 3'd3) $display("FAIL basic_count3 got %0d exp 3", byte_count); else passed++;
    drive_byte(8'h44);
    total++; if (pkt_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", pkt_valid); else passed++;
    total++; if (packet !== 32'h11223344) $display("FAIL basic_packet got %h exp 11223344", packet); else passed++;
    total++; if (byte_count !== 3'd0 || overflow !== 1'b0) $display("FAIL basic_count_ovf got %0d/%b exp 0/0", byte_count, overflow); else passed++;
    @(negedge clk);
    total++; if (pkt_valid !== 1'b0 || packet !== 32'h11223344) $display("FAIL basic_drain got %b/%h exp 0/11223344", pkt_valid, packet); else passed++;
  endtask

  task automatic test_back_to_back();
    pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_byte(8'hB0 + 8'(i));
    total++; if (pkt_valid !== 1'b1 || packet !== 32'hB0B1B2B3) $display("FAIL b2b_first got %b/%h exp 1/b0b1b2b3", pkt_valid, packet); else passed++;
    for (int i = 4; i < 8; i++) begin
      total++; if (byte_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", byte_ready); else passed++;
      drive_byte(8'hB0 + 8'(i));
    end
    total++; if (pkt_valid !== 1'b1 || packet !== 32'hB4B5B6B7) $display("FAIL b2b_second got %b/%h exp 1/b4b5b6b7", pkt_valid, packet); else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure_overflow();
    pkt_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_byte(8'hA0 + 8'(i));
    total++; if (packet !== 32'hA0A1A2A3 || pkt_valid !== 1'b1) $display("FAIL bp_held got %b/%h exp 1/a0a1a2a3", pkt_valid, packet); else passed++;
    total++; if (byte_ready !== 1'b0) $display("FAIL bp_ready_low got %b exp 0", byte_ready); else passed++;
    total++; if (byte_count !== 3'd4) $display("FAIL bp_count got %0d exp 4", byte_count); else passed++;
    drive_byte(8'h55);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else passed++;
    total++; if (byte_count !== 3'd4 || byte_ready !== 1'b0) $display("FAIL ovf_hold got %0d/%b exp 4/0", byte_count, byte_ready); else passed++;
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    total++; if (packet !== 32'hA4A5A6A7 || pkt_valid !== 1'b1) $display("FAIL bp_second got %b/%h exp 1/a4a5a6a7", pkt_valid, packet); else passed++;
    total++; if (byte_ready !== 1'b1 || byte_count !== 3'd0) $display("FAIL bp_refill got %b/%0d exp 1/0", byte_ready, byte_count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passed++;
    pkt_ready = 1'b1;
    @(negedge clk);
    total++; if (pkt_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", pkt_valid); else passed++;
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03); drive_byte(8'h04);
    total++; if (packet !== 32'h01020304 || pkt_valid !== 1'b1) $display("FAIL ovf_next_pkt got %b/%h exp 1/01020304", pkt_valid, packet); else passed++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passed++;
  endtask

  task automatic test_clear();
    pkt_ready = 1'b0;
    drive_byte(8'hD0); drive_byte(8'hD1); drive_byte(8'hD2); drive_byte(8'hD3);
    drive_byte(8'hC1); drive_byte(8'hC2);
    total++; if (pkt_valid !== 1'b1 || byte_count !== 3'd2) $display("FAIL clr_pre got %b/%0d exp 1/2", pkt_valid, byte_count); else passed++;
    clear = 1'b1;
    pkt_ready = 1'b1;
    drive_byte(8'hC3);
    clear = 1'b0;
    total++; if (byte_count !== 3'd0 || pkt_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL clr_state got %0d/%b/%b exp 0/0/0", byte_count, pkt_valid, overflow); else passed++;
    drive_byte(8'hE0); drive_byte(8'hE1); drive_byte(8'hE2); drive_byte(8'hE3);
    total++; if (packet !== 32'hE0E1E2E3 || pkt_valid !== 1'b1) $display("FAIL clr_next_pkt got %b/%h exp 1/e0e1e2e3", pkt_valid, packet); else passed++;
    @(negedge clk);
  endtask

`ifdef PKT_ASM_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    pkt_ready = 1'b1;
    drive_byte(8'h71); drive_byte(8'h72);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    total++; if (byte_count !== 3'd2) $display("FAIL to_before got %0d exp 2", byte_count); else passed++;
    @(negedge clk);
    total++; if (timeout !== 1'b1 || byte_count !== 3'd0) $display("FAIL to_pulse got %b/%0d exp 1/0", timeout, byte_count); else passed++;
    pulses++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) $display("FAIL to_once got %0d exp 1", pulses); else passed++;
    drive_byte(8'h81); drive_byte(8'h82); drive_byte(8'h83); drive_byte(8'h84);
    total++; if (packet !== 32'h81828384 || pkt_valid !== 1'b1) $display("FAIL to_next_pkt got %b/%h exp 1/81828384", pkt_valid, packet); else passed++;
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset();
    pkt_ready = 1'b0;
    drive_byte(8'hF0); drive_byte(8'hF1); drive_byte(8'hF2); drive_byte(8'hF3);
    drive_byte(8'hF4); drive_byte(8'hF5); drive_byte(8'hF6);
    total++; if (byte_count !== 3'd3 || pkt_valid !== 1'b1) $display("FAIL ar_pre got %0d/%b exp 3/1", byte_count, pkt_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pkt_valid !== 1'b0 || byte_count !== 3'd0) $display("FAIL ar_ctrl got %b/%0d exp 0/0", pkt_valid, byte_count); else passed++;
    total++; if (packet !== 32'h0 || byte_ready !== 1'b1 || overflow !== 1'b0) $display("FAIL ar_data got %h/%b/%b exp 0/1/0", packet, byte_ready, overflow); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_data = '0; pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_back_to_back();
    test_backpressure_overflow();
    test_clear();
`ifdef PKT_ASM_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
